// File: rtl/ttl_fifo_pkg.sv
// Shared defaults and types for the TTL FIFO controller and its storage.
package ttl_fifo_pkg;

    localparam int DEF_DEPTH     = 1024;
    localparam int DEF_THRESHOLD = 1000;
    localparam int DEF_DATA_LEN  = 8;
    localparam int DEF_ADDR_LEN  = 10;
    localparam int COUNT_W       = DEF_ADDR_LEN + 1;

    // Handshake combination seen in one cycle: {pop, push}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } op_e;

endpackage

// File: rtl/ttl_fifo_adj_fifo.sv
// Storage array for the TTL FIFO: synchronous write, asynchronous (fall-through) read.
// Contents are cleared by rst only, so the head data reads 0 after reset.
module adj_fifo
    import ttl_fifo_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int DATA_LEN = DEF_DATA_LEN,
    parameter int ADDR_LEN = DEF_ADDR_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_LEN-1:0] addr_in,
    input  logic [ADDR_LEN-1:0] addr_out,
    input  logic [DATA_LEN-1:0] din,
    output logic [DATA_LEN-1:0] dout
);

    logic [DATA_LEN-1:0] mem_r [0:DEPTH-1];

    // Clear every entry on reset, otherwise write the accepted word.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_LEN{1'b0}};
            end
        end else if (wr_en) begin
            mem_r[addr_in] <= din;
        end
    end

    assign dout = mem_r[addr_out];

endmodule

// File: rtl/ttl_fifo_ctrl.sv
// FIFO controller: pointers, occupancy count, status flags and high-water mark.
// All flags come from the registered count so ready/valid never depend on inputs.
module ttl_fifo_ctrl
    import ttl_fifo_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int THRESHOLD = DEF_THRESHOLD,
    parameter int DATA_LEN  = DEF_DATA_LEN,
    parameter int ADDR_LEN  = DEF_ADDR_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_LEN-1:0] s_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DATA_LEN-1:0] m_data,
    output logic [ADDR_LEN:0]   count,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic [ADDR_LEN:0]   hwm
);

    localparam int CW = ADDR_LEN + 1;
    localparam logic [CW-1:0]       DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0]       THRESH_C = CW'(THRESHOLD);
    localparam logic [ADDR_LEN-1:0] LAST_PTR = ADDR_LEN'(DEPTH - 1);

    logic [ADDR_LEN-1:0] wr_ptr_r, rd_ptr_r;
    logic [ADDR_LEN-1:0] wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic [CW-1:0]       count_r, count_nxt_s, hwm_r;
    logic                full_s, empty_s, push_s, pop_s;
    op_e                 op_s;

    // Pointer increment with explicit wrap, so DEPTH need not be a power of two.
    function automatic logic [ADDR_LEN-1:0] next_ptr(input logic [ADDR_LEN-1:0] p);
        if (p == LAST_PTR) begin
            return {ADDR_LEN{1'b0}};
        end else begin
            return p + ADDR_LEN'(1);
        end
    endfunction

    assign full_s      = (count_r == DEPTH_C);
    assign empty_s     = (count_r == CW'(0));
    assign full        = full_s;
    assign empty       = empty_s;
    assign almost_full = (count_r >= THRESH_C);
    assign s_ready     = ~full_s;
    assign m_valid     = ~empty_s;
    assign count       = count_r;
    assign hwm         = hwm_r;

    // Qualify handshakes; flush suppresses both so nothing is written or consumed.
    always_comb begin
        push_s = s_valid & ~full_s & ~flush;
        pop_s  = m_ready & ~empty_s & ~flush;
        op_s   = op_e'({pop_s, push_s});
    end

    // Next pointer and occupancy values from the qualified handshakes.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        if (push_s) begin
            wr_ptr_nxt_s = next_ptr(wr_ptr_r);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = next_ptr(rd_ptr_r);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case (op_s)
            OP_PUSH: count_nxt_s = count_r + CW'(1);
            OP_POP:  count_nxt_s = count_r - CW'(1);
            OP_IDLE: count_nxt_s = count_r;
            OP_BOTH: count_nxt_s = count_r;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer and count registers; reset and flush both clear them.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {ADDR_LEN{1'b0}};
            rd_ptr_r <= {ADDR_LEN{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
        end
    end

    // High-water mark follows the registered count one cycle behind.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            hwm_r <= {CW{1'b0}};
        end else if (count_r > hwm_r) begin
            hwm_r <= count_r;
        end
    end

    adj_fifo #(
        .DEPTH    (DEPTH),
        .DATA_LEN (DATA_LEN),
        .ADDR_LEN (ADDR_LEN)
    ) u_adj_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (push_s),
        .addr_in  (wr_ptr_r),
        .addr_out (rd_ptr_r),
        .din      (s_data),
        .dout     (m_data)
    );

endmodule

// File: tb/tb_ttl_fifo_ctrl.sv
// Scoreboard bench for ttl_fifo_ctrl: a directed driver plus a negedge monitor
// holding a reference queue of accepted words.
module tb_ttl_fifo_ctrl;

    localparam int DEPTH = 1024;
    localparam int THR   = 1000;

    logic        clk = 1'b0;
    logic        rst, flush, s_valid, s_ready, m_valid, m_ready;
    logic        full, empty, almost_full;
    logic [7:0]  s_data, m_data;
    logic [10:0] count, hwm;

    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    logic [7:0] exp_q[$];
    int         mdl_hwm = 0;
    int         cnt;

    ttl_fifo_ctrl #(
        .DEPTH(DEPTH), .THRESHOLD(THR), .DATA_LEN(8), .ADDR_LEN(10)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .hwm(hwm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare status against the reference queue, then apply this cycle's handshakes.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cnt = exp_q.size();
                chk("count", 32'(count), cnt);
                chk("empty", 32'(empty), 32'(cnt == 0));
                chk("full", 32'(full), 32'(cnt == DEPTH));
                chk("almost_full", 32'(almost_full), 32'(cnt >= THR));
                chk("s_ready", 32'(s_ready), 32'(cnt != DEPTH));
                chk("m_valid", 32'(m_valid), 32'(cnt != 0));
                chk("hwm", 32'(hwm), mdl_hwm);
                if (rst || flush) begin
                    exp_q.delete();
                    mdl_hwm = 0;
                end else begin
                    if (cnt > mdl_hwm) mdl_hwm = cnt;
                    if (m_ready && cnt != 0) begin
                        chk("m_data", 32'(m_data), 32'(exp_q[0]));
                        void'(exp_q.pop_front());
                    end
                    if (s_valid && cnt != DEPTH) exp_q.push_back(s_data);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        int sent;
        int guard;
        bit acc;
        rst = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = 8'h00;
        step(); step();
        rst = 1'b0;
        mon_en = 1'b1;
        chk("rst_s_ready", 32'(s_ready), 1);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);

        // First push into empty queue falls through.
        s_valid = 1'b1; s_data = 8'hA5; step(); s_valid = 1'b0;
        chk("a5_m_valid", 32'(m_valid), 1);
        chk("a5_m_data", 32'(m_data), 32'h0000_00A5);
        chk("a5_count", 32'(count), 1);
        m_ready = 1'b1; step(); m_ready = 1'b0;
        chk("a5_empty", 32'(empty), 1);

        // Fill to full, watching the almost_full edge.
        s_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            s_data = 8'(i);
            step();
            if (i == 998) chk("af_at_999", 32'(almost_full), 0);
            if (i == 999) chk("af_at_1000", 32'(almost_full), 1);
        end
        s_valid = 1'b0;
        chk("full_flag", 32'(full), 1);
        chk("full_s_ready", 32'(s_ready), 0);
        step();
        chk("hwm_1024", 32'(hwm), 1024);

        // Push and pop together while full: only the pop is taken.
        s_valid = 1'b1; s_data = 8'hEE; m_ready = 1'b1; step();
        s_valid = 1'b0; m_ready = 1'b0;
        chk("both_count", 32'(count), 1023);
        chk("both_s_ready", 32'(s_ready), 1);

        // Random-stall streaming; pointers wrap several times.
        sent = 0; guard = 0;
        while (sent < 3000 && guard < 30000) begin
            s_valid = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 2) != 0);
            s_data  = 8'(sent * 7 + 3);
            acc = s_valid && s_ready;
            step();
            if (acc) sent++;
            guard++;
        end
        chk("stream_sent", sent, 3000);
        s_valid = 1'b0; m_ready = 1'b1; guard = 0;
        while (count != 11'd0 && guard < 3000) begin
            step();
            guard++;
        end
        m_ready = 1'b0;
        chk("drain_count", 32'(count), 0);

        // Flush with push and pop at count 500.
        s_valid = 1'b1;
        for (int i = 0; i < 500; i++) begin
            s_data = 8'(i + 100);
            step();
        end
        chk("pre_flush_count", 32'(count), 500);
        flush = 1'b1; m_ready = 1'b1; s_data = 8'h5A; step();
        flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        chk("flush_count", 32'(count), 0);
        chk("flush_empty", 32'(empty), 1);
        chk("flush_hwm", 32'(hwm), 0);

        // Reset mid-stream at count 7.
        s_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            s_data = 8'(i + 200);
            step();
        end
        chk("pre_rst_count", 32'(count), 7);
        chk("pre_rst_m_data", 32'(m_data), 200);
        rst = 1'b1; m_ready = 1'b1; step();
        rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        chk("rst2_count", 32'(count), 0);
        chk("rst2_m_valid", 32'(m_valid), 0);
        chk("rst2_m_data", 32'(m_data), 0);
        chk("rst2_s_ready", 32'(s_ready), 1);
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
